// File: rtl/jt10_adpcmb_period.sv
// ADPCM-B sample-period sequencer: runs NUMER/delta_n on an external divider and
// emits one tick per period. Optional rounding of the quotient via JT10_ADPCMB_ROUND_EN.
module jt10_adpcmb_period #(
   parameter int          dw    = 16,
   parameter logic [dw-1:0] NUMER = 16'hFFFF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic [dw-1:0] delta_n,
   input  logic          dn_we,
   output logic          div_start,
   output logic [dw-1:0] div_a,
   output logic [dw-1:0] div_b,
   input  logic [dw-1:0] div_d,
   input  logic [dw-1:0] div_r,
   input  logic          div_busy,
   output logic [dw-1:0] period,
   output logic          period_vld,
   output logic          tick,
   output logic          busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_ARM, ST_WAIT} state_t;

   localparam logic [dw-1:0] ONE = {{(dw-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [dw-1:0] div_b_q, div_b_d;
   logic [dw-1:0] period_q, period_d;
   logic          vld_q, vld_d;
   logic [dw-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic [dw-1:0] pend_dn_q, pend_dn_d;
   logic [dw-1:0] latch_val;

`ifdef JT10_ADPCMB_ROUND_EN
   // Round half-up against the divisor actually in flight; never wrap past all-ones.
   logic [dw:0] r_x2;
   logic        round_up;
   assign r_x2      = {div_r, 1'b0};
   assign round_up  = r_x2 >= {1'b0, div_b_q};
   assign latch_val = (round_up && (div_d != '1)) ? div_d + ONE : div_d;
`else
   logic unused_r;
   assign unused_r  = ^div_r;
   assign latch_val = div_d;
`endif

   always_comb begin
      state_d   = state_q;
      div_b_d   = div_b_q;
      period_d  = period_q;
      vld_d     = vld_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_dn_d = pend_dn_q;
      tick      = 1'b0;
      if (cen) begin
         if (vld_q) begin
            if (cnt_q == period_q) begin
               tick  = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         // Writes during a division are parked; only the newest survives.
         if (dn_we && state_q != ST_IDLE) begin
            pend_d    = 1'b1;
            pend_dn_d = delta_n;
         end
         case (state_q)
            ST_IDLE: begin
               if (dn_we) begin
                  if (delta_n != '0) begin
                     div_b_d = delta_n;
                     state_d = ST_START;
                  end else begin
                     vld_d = 1'b0;
                     cnt_d = '0;
                  end
               end
            end
            ST_START: state_d = ST_ARM;
            ST_ARM:   state_d = ST_WAIT;
            ST_WAIT: begin
               if (!div_busy) begin
                  period_d = latch_val;
                  vld_d    = 1'b1;
                  cnt_d    = '0;
                  state_d  = ST_IDLE;
                  if (pend_d) begin
                     if (pend_dn_d != '0) begin
                        div_b_d = pend_dn_d;
                        state_d = ST_START;
                     end else begin
                        vld_d = 1'b0;
                     end
                  end
                  pend_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         div_b_q   <= '0;
         period_q  <= '0;
         vld_q     <= 1'b0;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         pend_dn_q <= '0;
      end else begin
         state_q   <= state_d;
         div_b_q   <= div_b_d;
         period_q  <= period_d;
         vld_q     <= vld_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_dn_q <= pend_dn_d;
      end
   end

   assign div_start  = (state_q == ST_START);
   assign div_a      = NUMER;
   assign div_b      = div_b_q;
   assign period     = period_q;
   assign period_vld = vld_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
